// File: rtl/output_array.sv
// output_array: serializes 4-pixel quads into a single pixel stream with
// line/frame markers. A two-entry ping-pong quad FIFO decouples the quad
// input from the pixel output so a quad every 4 cycles sustains 1 pixel/cycle.
// Optional feature macro: OUT_CLAMP_EN (signed clamp of output pixels to
// the range 0..MAX_VAL at the output mux).
module output_array #(
  parameter int LINE_WIDTH = 16,
  parameter int LINE_COUNT = 4,
  parameter int MAX_VAL    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        act,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_0,
  input  logic [14:0] in_1,
  input  logic [14:0] in_2,
  input  logic [14:0] in_3,
  output logic [14:0] out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sol,
  output logic        out_eol,
  output logic        out_eof
);

  localparam int DATA_W = 15;
  localparam int CW     = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int LNW    = (LINE_COUNT > 1) ? $clog2(LINE_COUNT) : 1;
  localparam logic [CW-1:0]  COL_LAST  = CW'(LINE_WIDTH - 1);
  localparam logic [LNW-1:0] LINE_LAST = LNW'(LINE_COUNT - 1);
  // An illegal geometry (or negative ceiling) leaves the block refusing input
  // rather than producing a stream with wrong markers.
  localparam bit CFG_OK = ((LINE_WIDTH % 4) == 0) && (LINE_WIDTH >= 4) &&
                          (LINE_COUNT >= 1) && (MAX_VAL >= 0);

  // Quad storage: data is never reset, only the control around it.
  logic [DATA_W-1:0] r_mem [2][4];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_occ;
  logic [1:0]        r_lane;
  logic [CW-1:0]     r_col;
  logic [LNW-1:0]    r_line;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pxfer;
  logic              w_pop;
  logic [DATA_W-1:0] w_lane_px;
  logic [DATA_W-1:0] w_px;

`ifdef OUT_CLAMP_EN
  // Treat the lane value as signed and limit it to 0..MAX_VAL.
  function automatic logic [DATA_W-1:0] clamp_px(input logic [DATA_W-1:0] raw);
    logic signed [DATA_W-1:0] s;
    s = $signed(raw);
    if (s < 0)
      return '0;
    else if (int'(s) > MAX_VAL)
      return DATA_W'(MAX_VAL);
    else
      return raw;
  endfunction
`endif

  // Handshakes depend only on registered state, act and rst.
  assign w_in_ready  = act && !rst && CFG_OK && (r_occ < 2'd2);
  assign w_out_valid = act && !rst && (r_occ != 2'd0);
  assign w_push      = in_valid && w_in_ready;
  assign w_pxfer     = w_out_valid && out_ready;
  assign w_pop       = w_pxfer && (r_lane == 2'd3);

  assign w_lane_px = r_mem[r_head][r_lane];
`ifdef OUT_CLAMP_EN
  assign w_px = clamp_px(w_lane_px);
`else
  assign w_px = w_lane_px;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out       = w_out_valid ? w_px : '0;
  assign out_sol   = w_out_valid && (r_col == '0);
  assign out_eol   = w_out_valid && (r_col == COL_LAST);
  assign out_eof   = w_out_valid && (r_col == COL_LAST) && (r_line == LINE_LAST);

  // Capture an accepted quad into the tail slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail][0] <= in_0;
      r_mem[r_tail][1] <= in_1;
      r_mem[r_tail][2] <= in_2;
      r_mem[r_tail][3] <= in_3;
    end
  end

  // FIFO pointers and occupancy; push and lane-3 pop together leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Lane, column and line counters advance on each pixel transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= 2'd0;
      r_col  <= '0;
      r_line <= '0;
    end else if (w_pxfer) begin
      r_lane <= r_lane + 2'd1;
      if (r_col == COL_LAST) begin
        r_col <= '0;
        if (r_line == LINE_LAST) r_line <= '0;
        else                     r_line <= r_line + LNW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_output_array.sv
// Directed bench for output_array with default geometry (16 x 4).
module tb_output_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        act = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
  logic [14:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sol, out_eol, out_eof;

  int checks = 0;
  int errors = 0;

  output_array #(.LINE_WIDTH(16), .LINE_COUNT(4), .MAX_VAL(255)) dut (
    .clk(clk), .rst(rst), .act(act),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quad(input logic [14:0] a, input logic [14:0] b,
                          input logic [14:0] c, input logic [14:0] d);
    in_0 = a; in_1 = b; in_2 = c; in_3 = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int q;
    bit acc;

    // ---- reset state ----
    act = 1'b1;
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_sol", int'(out_sol), 0);
    chk("rst_eol", int'(out_eol), 0);
    chk("rst_eof", int'(out_eof), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);

    // ---- two back-to-back quads, latency and order ----
    set_quad(15'd1, 15'd2, 15'd3, 15'd4);
    in_valid = 1'b1;
    tick();
    set_quad(15'd5, 15'd6, 15'd7, 15'd8);
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_out", int'(out), 1);
    chk("lat_sol", int'(out_sol), 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_out2", int'(out), 2);
    chk("b2b_sol2", int'(out_sol), 0);
    chk("b2b_full", int'(in_ready), 0);
    for (int p = 3; p <= 8; p++) begin
      tick();
      chk("b2b_valid", int'(out_valid), 1);
      chk("b2b_out", int'(out), p);
    end
    tick();
    chk("b2b_empty_valid", int'(out_valid), 0);
    chk("b2b_empty_out", int'(out), 0);

    // ---- backpressure: third quad stalls, nothing lost ----
    apply_reset();
    out_ready = 1'b0;
    set_quad(15'd1, 15'd2, 15'd3, 15'd4);
    in_valid = 1'b1;
    tick();
    chk("bp_rdy_after1", int'(in_ready), 1);
    set_quad(15'd5, 15'd6, 15'd7, 15'd8);
    tick();
    chk("bp_rdy_after2", int'(in_ready), 0);
    set_quad(15'd9, 15'd10, 15'd11, 15'd12);
    tick();
    chk("bp_stall_rdy", int'(in_ready), 0);
    chk("bp_hold_out", int'(out), 1);
    tick();
    chk("bp_hold_out2", int'(out), 1);
    chk("bp_hold_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    for (int p = 1; p <= 12; p++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_out", int'(out), p);
      chk("bp_in_ready", int'(in_ready), int'(p == 5 || p >= 9));
      tick();
      if (p == 5) in_valid = 1'b0;
    end
    chk("bp_drain", int'(out_valid), 0);

    // ---- full frame of 64 pixels: sol/eol/eof markers ----
    apply_reset();
    out_ready = 1'b1;
    q = 0;
    set_quad(15'd1, 15'd2, 15'd3, 15'd4);
    in_valid = 1'b1;
    tick();
    q = 1;
    set_quad(15'(4*q+1), 15'(4*q+2), 15'(4*q+3), 15'(4*q+4));
    for (int p = 1; p <= 64; p++) begin
      chk("frm_valid", int'(out_valid), 1);
      chk("frm_out", int'(out), p);
      chk("frm_sol", int'(out_sol), int'((p % 16) == 1));
      chk("frm_eol", int'(out_eol), int'((p % 16) == 0));
      chk("frm_eof", int'(out_eof), int'(p == 64));
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        q++;
        if (q == 16) in_valid = 1'b0;
        else set_quad(15'(4*q+1), 15'(4*q+2), 15'(4*q+3), 15'(4*q+4));
      end
    end
    chk("frm_done", int'(out_valid), 0);

    // ---- act drop after pixel 6 freezes everything ----
    apply_reset();
    out_ready = 1'b1;
    q = 0;
    set_quad(15'd1, 15'd2, 15'd3, 15'd4);
    in_valid = 1'b1;
    tick();
    q = 1;
    set_quad(15'd5, 15'd6, 15'd7, 15'd8);
    for (int p = 1; p <= 16; p++) begin
      chk("act_valid", int'(out_valid), 1);
      chk("act_out", int'(out), p);
      chk("act_sol", int'(out_sol), int'(p == 1));
      chk("act_eol", int'(out_eol), int'(p == 16));
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        q++;
        if (q == 4) in_valid = 1'b0;
        else set_quad(15'(4*q+1), 15'(4*q+2), 15'(4*q+3), 15'(4*q+4));
      end
      if (p == 6) begin
        act = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
          chk("act_low_valid", int'(out_valid), 0);
          chk("act_low_rdy", int'(in_ready), 0);
          chk("act_low_out", int'(out), 0);
          tick();
        end
        act = 1'b1;
        #1;
      end
    end
    chk("act_done", int'(out_valid), 0);

    // ---- reset mid-quad discards buffered pixels ----
    apply_reset();
    out_ready = 1'b1;
    set_quad(15'd1, 15'd2, 15'd3, 15'd4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mrst_p1", int'(out), 1);
    tick();
    chk("mrst_p2", int'(out), 2);
    tick();
    chk("mrst_p3_pending", int'(out), 3);
    rst = 1'b1;
    set_quad(15'd5, 15'd6, 15'd7, 15'd8);
    in_valid = 1'b1;
    #1;
    chk("mrst_during_valid", int'(out_valid), 0);
    chk("mrst_during_rdy", int'(in_ready), 0);
    chk("mrst_during_out", int'(out), 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mrst_after_valid", int'(out_valid), 0);
    chk("mrst_after_rdy", int'(in_ready), 1);
    set_quad(15'd9, 15'd10, 15'd11, 15'd12);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mrst_first_out", int'(out), 9);
    chk("mrst_first_sol", int'(out_sol), 1);
    for (int p = 10; p <= 12; p++) begin
      tick();
      chk("mrst_out", int'(out), p);
    end
    tick();
    chk("mrst_done", int'(out_valid), 0);

    // ---- clamp boundary values ----
    apply_reset();
    out_ready = 1'b1;
    set_quad(15'h7FFF, 15'd300, 15'd255, 15'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef OUT_CLAMP_EN
    chk("clamp_neg", int'(out), 0);
    tick();
    chk("clamp_hi", int'(out), 255);
    tick();
    chk("clamp_max", int'(out), 255);
    tick();
    chk("clamp_zero", int'(out), 0);
`else
    chk("raw_7fff", int'(out), 32767);
    tick();
    chk("raw_300", int'(out), 300);
    tick();
    chk("raw_255", int'(out), 255);
    tick();
    chk("raw_zero", int'(out), 0);
`endif
    chk("clamp_zero_valid", int'(out_valid), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_array.md
OUTPUT_ARRAY -- requirements
Module: output_array

Interface
REQ-001 Parameter LINE_WIDTH, default 16, pixels per output line; SHALL be a multiple of 4, minimum 4.
REQ-002 Parameter LINE_COUNT, default 4, lines per frame; minimum 1.
REQ-003 Parameter MAX_VAL, default 255, clamp ceiling; used only under OUT_CLAMP_EN.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 act  in  1  enable; when low the block freezes.
REQ-007 in_valid  in  1  quad on in_0..in_3 is valid.
REQ-008 in_ready  out  1  block accepts a quad this cycle.
REQ-009 in_0, in_1, in_2, in_3  in  15 each  four horizontally adjacent pixels, in_0 leftmost.
REQ-010 out  out  15  serialized pixel.
REQ-011 out_valid  out  1  out holds a valid pixel.
REQ-012 out_ready  in  1  downstream accepts pixel.
REQ-013 out_sol / out_eol / out_eof  out  1 each  first pixel of line / last pixel of line / last pixel of frame.

Function
REQ-014 Quad transfer: in_valid and in_ready both high at a rising edge; pixel transfer: out_valid and out_ready both high at a rising edge.
REQ-015 Storage: 2-entry quad FIFO (ping-pong), head/tail pointers, occupancy 0..2.
REQ-016 in_ready = act and not rst and occupancy < 2; depends only on registered state, act and rst, never on in_valid or out_ready.
REQ-017 out_valid = act and occupancy > 0; out = head quad lane selected by lane counter (0..3); out = 0 whenever out_valid = 0.
REQ-018 Lane order: in_0, in_1, in_2, in_3; on each pixel transfer lane increments; transfer at lane 3 pops head, lane -> 0.
REQ-019 Latency: quad accepted at edge N into empty FIFO -> out_valid high with in_0 value in the cycle after edge N.
REQ-020 Throughput: 1 pixel/cycle sustained when out_ready held high and a quad is offered every 4 cycles; no bubbles.
REQ-021 Simultaneous push and lane-3 pop: occupancy unchanged; both pointers advance.
REQ-022 Full (occupancy 2): in_ready low; no push even if lane-3 pop occurs that cycle.
REQ-023 Data held stable on out while out_valid high and out_ready low.
REQ-024 Column counter 0..LINE_WIDTH-1 advances per pixel transfer, wraps to 0; line counter 0..LINE_COUNT-1 advances on column wrap, wraps to 0.
REQ-025 out_sol = out_valid and col = 0; out_eol = out_valid and col = LINE_WIDTH-1; out_eof = out_eol and line = LINE_COUNT-1.
REQ-026 act low: in_ready = 0, out_valid = 0, no transfers; FIFO contents, pointers, lane, col, line held; resume unchanged when act returns high.

Reset
REQ-027 rst high at an edge: occupancy, head, tail, lane, col, line -> 0; FIFO data not cleared.
REQ-028 Output values during and after reset: out_valid 0, in_ready 0 (during), out 0, out_sol/out_eol/out_eof 0.
REQ-029 rst mid-line or mid-quad: buffered pixels discarded; first transfer after reset is in_0 of the next accepted quad with out_sol = 1.
REQ-030 rst takes priority over act and all transfers in the same cycle.

Configuration
REQ-031 Macro OUT_CLAMP_EN defined: input pixels treated as 15-bit two's-complement; out = 0 if negative, MAX_VAL if > MAX_VAL, else value; clamp applied at output mux.
REQ-032 OUT_CLAMP_EN undefined: out is the raw 15-bit lane value, no clamp logic instantiated.

Verification
REQ-033 Reset then act=1, out_ready=1, quads (1,2,3,4),(5,6,7,8) on consecutive accepts -> out 1..8 on 8 consecutive cycles, out_sol on 1, first valid cycle one cycle after first accept.
REQ-034 out_ready=0, push 3 quads -> third quad stalls with in_ready=0 after two accepts; release out_ready -> all 12 pixels in order, none lost or duplicated.
REQ-035 Stream 64 pixels (values 1..64), LINE_WIDTH=16, LINE_COUNT=4 -> out_eol on 16,32,48,64; out_sol on 1,17,33,49; out_eof only on 64.
REQ-036 Drop act for 10 cycles after pixel 6 -> out_valid and in_ready low, nothing moves; on act=1 pixel 7 follows with correct col.
REQ-037 rst pulse after pixel 2 of quad (1,2,3,4) -> pixels 3,4 never appear; next quad (9,10,11,12) emits 9 with out_sol=1.
REQ-038 OUT_CLAMP_EN, MAX_VAL=255, quad (0x7FFF, 300, 255, 0) -> out 0, 255, 255, 0; without macro -> 0x7FFF, 300, 255, 0.
